dbus_ctrl: RTL and testbench

Sequencer between the pipeline memory stage and the data bus. Latches one load/store per memory-stage instruction, holds a stable `dbus_req_t` until `data_ok`, and generates byte strobes and lane-shifted write data from size and address. It returns sign- or zero-extended load data and a stall that freezes the pipeline while the access is outstanding. Sits between the memory stage and the `dreq`/`dresp` ports of the core.

---
 rtl/dbus_ctrl_pkg.sv | 48 ++++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/dbus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dbus_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_ctrl_pkg.sv
// rtl/dbus_ctrl_pkg.sv - Bus request/response types, access sizes and FSM states for dbus_ctrl.
package dbus_ctrl_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef logic [1:0] dbus_ctrl_state_t;

  localparam dbus_ctrl_state_t ST_IDLE  = 2'd0;
  localparam dbus_ctrl_state_t ST_BUSY  = 2'd1;
  localparam dbus_ctrl_state_t ST_DONE  = 2'd2;
  localparam dbus_ctrl_state_t ST_DRAIN = 2'd3;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_low_mask(msize_t size);
    logic [2:0] mask;
    case (size)
      MSIZE1:  mask = 3'b000;
      MSIZE2:  mask = 3'b001;
      MSIZE4:  mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - Byte-lane shaping: store strobe/shifted data, or extended load data.
module mem_lane_align
  import dbus_ctrl_pkg::*;
(
  input  msize_t      size_i,
  input  logic [2:0]  offset_i,
  input  logic        load_i,
  input  logic        unsigned_i,
  input  logic [63:0] data_i,
  output logic [7:0]  strobe_o,
  output logic [63:0] data_o
);

  logic [5:0]  shamt;
  logic [63:0] down;
  logic        sext;

  assign shamt = {offset_i, 3'b000};
  assign down  = data_i >> shamt;

  always_comb begin
    strobe_o = 8'h00;
    data_o   = 64'd0;
    sext     = 1'b0;
    if (load_i) begin
      case (size_i)
        MSIZE1: begin
          sext   = !unsigned_i && down[7];
          data_o = {{56{sext}}, down[7:0]};
        end
        MSIZE2: begin
          sext   = !unsigned_i && down[15];
          data_o = {{48{sext}}, down[15:0]};
        end
        MSIZE4: begin
          sext   = !unsigned_i && down[31];
          data_o = {{32{sext}}, down[31:0]};
        end
        default: data_o = down;
      endcase
    end else begin
      // Lanes shifted past byte 7 are dropped; the bus word is 8 bytes wide.
      data_o = data_i << shamt;
      case (size_i)
        MSIZE1:  strobe_o = 8'h01 << offset_i;
        MSIZE2:  strobe_o = 8'h03 << offset_i;
        MSIZE4:  strobe_o = 8'h0F << offset_i;
        default: strobe_o = 8'hFF;
      endcase
    end
  end

endmodule

// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - Memory-stage data bus sequencer; DBUS_CTRL_MISALIGN_CHECK_EN enables misalign reporting.
module dbus_ctrl
  import dbus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  msize_t      req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  input  logic        kill,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic [63:0] rdata,
  output logic        done,
  output logic        stall
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  dbus_ctrl_state_t state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  msize_t           size_q, size_d;
  logic             write_q, write_d;
  logic             unsigned_q, unsigned_d;

  logic             accept;
  logic [63:0]      accept_addr;
  logic [7:0]       wr_strobe, rd_strobe;
  logic [63:0]      wr_data, rd_data;
  logic             unused_addr_ok;

  assign accept         = (state_q == ST_IDLE) && req_valid && !kill;
  assign unused_addr_ok = dresp.addr_ok;

`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic addr_misaligned;

  assign addr_misaligned = |(req_addr[2:0] & size_low_mask(req_size));
  assign accept_addr     = req_addr;
  assign misalign        = misalign_q && (state_q == ST_DONE);
`else
  assign accept_addr = {req_addr[63:3], req_addr[2:0] & ~size_low_mask(req_size)};
`endif

  mem_lane_align u_wr_align (
    .size_i     (size_q),
    .offset_i   (addr_q[2:0]),
    .load_i     (1'b0),
    .unsigned_i (unsigned_q),
    .data_i     (wdata_q),
    .strobe_o   (wr_strobe),
    .data_o     (wr_data)
  );

  mem_lane_align u_rd_align (
    .size_i     (size_q),
    .offset_i   (addr_q[2:0]),
    .load_i     (1'b1),
    .unsigned_i (unsigned_q),
    .data_i     (dresp.data),
    .strobe_o   (rd_strobe),
    .data_o     (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d     = accept_addr;
          size_d     = req_size;
          write_d    = req_write;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
          misalign_d = addr_misaligned;
          if (addr_misaligned) begin
            rdata_d = 64'd0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
`else
          state_d    = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        // A kill never withdraws a request the bus may already have taken.
        if (dresp.data_ok) begin
          if (kill) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d = rd_data;
            state_d = ST_DONE;
          end
        end else if (kill) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dresp.data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= 64'd0;
      size_q     <= MSIZE1;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 64'd0;
      rdata_q    <= 64'd0;
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_comb begin
    dreq = '0;
    if (state_q == ST_BUSY || state_q == ST_DRAIN) begin
      dreq.valid  = 1'b1;
      dreq.addr   = addr_q;
      dreq.size   = size_q;
      dreq.strobe = write_q ? wr_strobe : rd_strobe;
      dreq.data   = wr_data;
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == ST_DONE) && !kill;
  assign stall = (req_valid && (state_q != ST_DONE) && !kill) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb/tb_dbus_ctrl.sv - Scoreboard bench for dbus_ctrl against a byte-lane reference model.
module tb_dbus_ctrl;
  import dbus_ctrl_pkg::*;

  localparam int P_IDLE  = 0;
  localparam int P_BUSY  = 1;
  localparam int P_DONE  = 2;
  localparam int P_DRAIN = 3;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } pay_t;

  typedef struct {
    logic        is_load;
    logic [63:0] rdata;
    logic        mis;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned, kill;
  logic [63:0] req_addr, req_wdata;
  msize_t      req_size;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic [63:0] rdata;
  logic        done, stall;
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  pay_t    pay_q[$];
  res_t    res_q[$];
  int      done_cyc[$];
  int      checks = 0;
  int      passed = 0;
  int      cyc = 0;
  int      phase = P_IDLE;
  bit      mon_en = 1'b0;
  pay_t    mp;
  res_t    mr;

  always #5 clk = ~clk;

  dbus_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .kill         (kill),
    .dreq         (dreq),
    .dresp        (dresp),
    .rdata        (rdata),
    .done         (done),
    .stall        (stall)
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
    , .misalign   (misalign)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic pay_t mk_pay(logic wr, logic [63:0] a, logic [2:0] sz, logic [7:0] st, logic [63:0] d);
    pay_t p;
    p.write = wr; p.addr = a; p.size = sz; p.strobe = st; p.data = d;
    return p;
  endfunction

  function automatic bit model_mis(logic [63:0] a, logic [2:0] sz);
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
    return (a % (64'd1 << sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic pay_t model_pay(logic [63:0] a, logic [2:0] sz, logic wr, logic [63:0] wd);
    pay_t        p;
    int          n, off;
    logic [63:0] al;
    n   = 1 << sz;
    al  = a - (a % n);
    off = int'(al % 8);
    p.write  = wr;
    p.addr   = al;
    p.size   = sz;
    p.strobe = wr ? 8'(((1 << n) - 1) << off) : 8'h00;
    p.data   = wd << (8 * off);
    return p;
  endfunction

  function automatic logic [63:0] model_rdata(logic [63:0] bus, logic [63:0] al, logic [2:0] sz, logic un);
    int          n, off;
    logic [63:0] v, mask;
    n   = 1 << sz;
    off = int'(al % 8);
    v   = bus >> (8 * off);
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v    = v & mask;
      if (!un && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Monitor: compares bus payload and completions against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      chk("dreq_valid", dreq.valid, phase == P_BUSY || phase == P_DRAIN);
      chk("done", done, phase == P_DONE && !kill);
      chk("stall", stall, (req_valid && phase != P_DONE && !kill) || phase == P_DRAIN);
      if (dreq.valid) begin
        if (pay_q.size() == 0) begin
          checks++;
          $display("FAIL bus_payload: request seen with no expected payload queued");
        end else begin
          mp = pay_q[0];
          chk("dreq_addr", dreq.addr, mp.addr);
          chk("dreq_size", dreq.size, mp.size);
          chk("dreq_strobe", dreq.strobe, mp.strobe);
          if (mp.write) chk("dreq_data", dreq.data, mp.data);
          if (dresp.data_ok) void'(pay_q.pop_front());
        end
      end
      if (done) begin
        done_cyc.push_back(cyc);
        if (res_q.size() == 0) begin
          checks++;
          $display("FAIL result: done seen with no expected result queued");
        end else begin
          mr = res_q.pop_front();
          if (mr.is_load || mr.mis) chk("rdata", rdata, mr.rdata);
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
          chk("misalign", misalign, mr.mis);
`endif
        end
      end
    end
  end

  // kill_at: -1 none; 0..waits-1 kill before data_ok (drain); waits kill with data_ok; waits+1 kill in DONE.
  task automatic run_txn(input logic [63:0] a, input logic [2:0] sz, input logic wr, input logic un,
                         input logic [63:0] wd, input logic [63:0] bus, input int waits, input int kill_at,
                         input int drain_waits, input pay_t ep, input logic [63:0] erd, input bit emis);
    res_t r;
    int   last;
    r.is_load = !wr; r.rdata = erd; r.mis = emis;
    if (!emis) pay_q.push_back(ep);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = msize_t'(sz);
    req_unsigned = un; req_wdata = wd; kill = 1'b0; phase = P_IDLE;
    @(posedge clk); #1;
    if (emis) begin
      phase = P_DONE;
      res_q.push_back(r);
      @(posedge clk); #1;
    end else begin
      phase = P_BUSY;
      last = (kill_at >= 0 && kill_at < waits) ? kill_at : waits;
      for (int i = 0; i <= last; i++) begin
        kill = (i == kill_at);
        dresp.addr_ok = 1'($urandom_range(0, 1));
        dresp.data_ok = (i == waits);
        dresp.data = (i == waits) ? bus : {$urandom, $urandom};
        @(posedge clk); #1;
      end
      kill = 1'b0; dresp.data_ok = 1'b0; dresp.addr_ok = 1'b0;
      if (kill_at >= 0 && kill_at < waits) begin
        req_valid = 1'b0; phase = P_DRAIN;
        for (int j = 0; j <= drain_waits; j++) begin
          dresp.data_ok = (j == drain_waits);
          dresp.data = {$urandom, $urandom};
          @(posedge clk); #1;
        end
        dresp.data_ok = 1'b0;
      end else if (kill_at != waits) begin
        phase = P_DONE;
        kill = (kill_at == waits + 1);
        if (!kill) res_q.push_back(r);
        @(posedge clk); #1;
        kill = 1'b0;
      end
    end
    phase = P_IDLE; req_valid = 1'b0;
  endtask

  task automatic run_random();
    logic [63:0] a, wd, bus;
    logic [2:0]  sz;
    logic        wr, un;
    int          waits, kill_at;
    pay_t        ep;
    bit          mis;
    sz  = 3'($urandom_range(0, 3));
    a   = {$urandom, $urandom};
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
    if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
`endif
    wr  = 1'($urandom_range(0, 1));
    un  = 1'($urandom_range(0, 1));
    wd  = {$urandom, $urandom};
    bus = {$urandom, $urandom};
    waits   = $urandom_range(0, 3);
    kill_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, waits + 1) : -1;
    mis = model_mis(a, sz);
    ep  = model_pay(a, sz, wr, wd);
    run_txn(a, sz, wr, un, wd, bus, waits, kill_at, $urandom_range(0, 2), ep,
            mis ? 64'd0 : model_rdata(bus, ep.addr, sz, un), mis);
  endtask

  initial begin
    int n0;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_size = MSIZE1;
    req_unsigned = 1'b0; req_wdata = 64'd0; kill = 1'b0; dresp = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_dreq_valid", dreq.valid, 1'b0);
    chk("rst_dreq_word", dreq.addr | dreq.data | 64'(dreq.strobe), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, 1'b0);
    mon_en = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn(64'h8000_0003, 3'd0, 1'b1, 1'b0, 64'hAB, 64'h0, 0, -1, 0,
            mk_pay(1'b1, 64'h8000_0003, 3'd0, 8'h08, 64'h0000_0000_AB00_0000), 64'd0, 1'b0);
    run_txn(64'h8000_1006, 3'd1, 1'b0, 1'b0, 64'h0, 64'h8123_0000_0000_0000, 3, -1, 0,
            mk_pay(1'b0, 64'h8000_1006, 3'd1, 8'h00, 64'h0), 64'hFFFF_FFFF_FFFF_8123, 1'b0);
    run_txn(64'h8000_1006, 3'd1, 1'b0, 1'b1, 64'h0, 64'h8123_0000_0000_0000, 3, -1, 0,
            mk_pay(1'b0, 64'h8000_1006, 3'd1, 8'h00, 64'h0), 64'h0000_0000_0000_8123, 1'b0);

    // Reset while BUSY abandons the access.
    pay_q.push_back(mk_pay(1'b0, 64'h8000_2010, 3'd2, 8'h00, 64'h0));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h8000_2010; req_size = MSIZE4;
    phase = P_IDLE;
    @(posedge clk); #1;
    phase = P_BUSY; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; phase = P_IDLE; pay_q.delete();
    chk("midrst_dreq_valid", dreq.valid, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_rdata", rdata, 64'd0);
    @(posedge clk); #1;

    // Kill on the second BUSY cycle, drain two waits, then a normal access.
    run_txn(64'h8000_4000, 3'd3, 1'b1, 1'b0, 64'h1122_3344_5566_7788, 64'h0, 4, 1, 2,
            mk_pay(1'b1, 64'h8000_4000, 3'd3, 8'hFF, 64'h1122_3344_5566_7788), 64'd0, 1'b0);
    run_txn(64'h8000_4004, 3'd2, 1'b0, 1'b0, 64'h0, 64'h8000_0001_0000_0000, 0, -1, 0,
            mk_pay(1'b0, 64'h8000_4004, 3'd2, 8'h00, 64'h0), 64'hFFFF_FFFF_8000_0001, 1'b0);

    // Back-to-back ld then sd on a 0-wait bus.
    n0 = done_cyc.size();
    run_txn(64'h8000_5000, 3'd3, 1'b0, 1'b0, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 0, -1, 0,
            mk_pay(1'b0, 64'h8000_5000, 3'd3, 8'h00, 64'h0), 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    run_txn(64'h8000_5008, 3'd3, 1'b1, 1'b0, 64'hCAFE_0000_1234_5678, 64'h0, 0, -1, 0,
            mk_pay(1'b1, 64'h8000_5008, 3'd3, 8'hFF, 64'hCAFE_0000_1234_5678), 64'd0, 1'b0);
    if (done_cyc.size() >= n0 + 2) chk("b2b_spacing", 64'(done_cyc[n0+1] - done_cyc[n0]), 64'd3);
    else begin
      checks++;
      $display("FAIL b2b_spacing: got %0d done pulses, expected 2", done_cyc.size() - n0);
    end

`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
    run_txn(64'h8000_3002, 3'd2, 1'b0, 1'b0, 64'h0, 64'h0, 0, -1, 0,
            mk_pay(1'b0, 64'h0, 3'd2, 8'h00, 64'h0), 64'd0, 1'b1);
`else
    run_txn(64'h8000_3002, 3'd2, 1'b1, 1'b0, 64'h0000_0000_A5A5_5A5A, 64'h0, 0, -1, 0,
            mk_pay(1'b1, 64'h8000_3000, 3'd2, 8'h0F, 64'h0000_0000_A5A5_5A5A), 64'd0, 1'b0);
`endif

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_valid = 1'b1; kill = 1'b1; req_addr = {$urandom, $urandom};
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      run_random();
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pay_q_drained", 64'(pay_q.size()), 64'd0);
    chk("res_q_drained", 64'(res_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
